// File: rtl/memshare_pkg.sv
// Shared definitions for the memory-share scheduler: state encoding,
// default port count and the round-count helper.
package memshare_pkg;

  // Scheduler state encoding
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  // Default number of physical shared banks in GP2
  localparam int DEFAULT_SHARE_PORT_NUM = 2;

  // Number of rounds needed to serve n flagged requestors on p banks
  function automatic int round_count(input int n, input int p);
    return (n + p - 1) / p;
  endfunction

endpackage

// File: rtl/lowest_k_select.sv
// Combinational picker: keeps the lowest-index K set bits of mask_i,
// or every set bit when fewer than K are set.
module lowest_k_select #(
  parameter int N = 5,
  parameter int K = 2
) (
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] sel_o
);

  int cnt;

  // Scan from bit 0 upward, accepting set bits until K have been taken
  always_comb begin
    sel_o = '0;
    cnt   = 0;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i] && (cnt < K)) begin
        sel_o[i] = 1'b1;
        cnt      = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/memshare_sched_ctrl.sv
// Memory-share scheduler: accepts one snapshot of shared-access flags and
// serialises the flagged requestors onto SHARE_PORT_NUM banks, one round
// per output beat. GP1 requestors are released with round 0 only.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. rqst_valid_i/rqst_ready_o move a snapshot in; grant_valid_o/
// grant_ready_i move a round beat out. While grant_valid_o is high and
// grant_ready_i is low, every beat output is held stable.
module memshare_sched_ctrl
  import memshare_pkg::*;
#(
  parameter int SHARED_BANK_NUM = 5,
  parameter int SHARE_PORT_NUM  = DEFAULT_SHARE_PORT_NUM,
  parameter int ROUND_WIDTH     = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       rqst_valid_i,
  output logic                       rqst_ready_o,
  input  logic [SHARED_BANK_NUM-1:0] share_rqstFlag_i,
  output logic                       grant_valid_o,
  input  logic                       grant_ready_i,
  output logic [SHARED_BANK_NUM-1:0] grant_o,
  output logic [SHARED_BANK_NUM-1:0] invalid_pos_o,
  output logic                       gp1_en_o,
  output logic [ROUND_WIDTH-1:0]     round_o,
  output logic                       end_flag_o,
  output logic [0:0]                 dbg_state_o
);

  logic [0:0]                 state_q, state_d;
  logic [SHARED_BANK_NUM-1:0] pending_q, pending_d;
  logic                       valid_q, valid_d;
  logic [SHARED_BANK_NUM-1:0] grant_q, grant_d;
  logic [SHARED_BANK_NUM-1:0] inval_q, inval_d;
  logic                       gp1_q, gp1_d;
  logic [ROUND_WIDTH-1:0]     round_q, round_d;
  logic                       end_q, end_d;

  logic                       beat_free;
  logic                       accept;
  logic [SHARED_BANK_NUM-1:0] pick_in;
  logic [SHARED_BANK_NUM-1:0] pick_out;
  logic [SHARED_BANK_NUM-1:0] remain;

  // Output slot can take a new beat when empty or being drained this edge
  assign beat_free    = !valid_q || grant_ready_i;
  assign rqst_ready_o = (state_q == IDLE) && beat_free;
  assign accept       = rqst_valid_i && rqst_ready_o;

  // One picker shared between the fresh snapshot and the pending mask
  assign pick_in = (state_q == IDLE) ? share_rqstFlag_i : pending_q;
  assign remain  = pick_in & ~pick_out;

  lowest_k_select #(
    .N (SHARED_BANK_NUM),
    .K (SHARE_PORT_NUM)
  ) u_pick (
    .mask_i (pick_in),
    .sel_o  (pick_out)
  );

  // Next-state and next-beat computation
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    grant_d   = grant_q;
    inval_d   = inval_q;
    gp1_d     = gp1_q;
    round_d   = round_q;
    end_d     = end_q;

    if (state_q == IDLE) begin
      if (accept) begin
        grant_d   = pick_out;
        pending_d = remain;
        inval_d   = remain;
        gp1_d     = 1'b1;
        round_d   = '0;
        valid_d   = 1'b1;
        end_d     = (remain == '0);
        state_d   = (remain == '0) ? IDLE : SERVE;
      end else if (grant_ready_i) begin
        // Last beat drained with nothing new behind it
        valid_d   = 1'b0;
        grant_d   = '0;
        inval_d   = '0;
        gp1_d     = 1'b0;
        round_d   = '0;
        end_d     = 1'b0;
      end
    end else begin
      if (grant_ready_i) begin
        grant_d   = pick_out;
        pending_d = remain;
        inval_d   = remain;
        gp1_d     = 1'b0;
        round_d   = round_q + ROUND_WIDTH'(1);
        end_d     = (remain == '0);
        if (remain == '0) begin
          state_d = IDLE;
        end
      end
    end
  end

  // State and beat registers, cleared asynchronously on reset
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      inval_q   <= '0;
      gp1_q     <= 1'b0;
      round_q   <= '0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      inval_q   <= inval_d;
      gp1_q     <= gp1_d;
      round_q   <= round_d;
      end_q     <= end_d;
    end
  end

  assign grant_valid_o = valid_q;
  assign grant_o       = grant_q;
  assign invalid_pos_o = inval_q;
  assign gp1_en_o      = gp1_q;
  assign round_o       = round_q;
  assign end_flag_o    = end_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Directed bench for memshare_sched_ctrl with 5 requestors on 2 banks.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_memshare_sched_ctrl;

  localparam int N  = 5;
  localparam int RW = 2;
  localparam int BW = 1 + N + N + 1 + RW + 1;

  logic          sys_clk;
  logic          rst;
  logic          rqst_valid_i;
  logic          rqst_ready_o;
  logic [N-1:0]  share_rqstFlag_i;
  logic          grant_valid_o;
  logic          grant_ready_i;
  logic [N-1:0]  grant_o;
  logic [N-1:0]  invalid_pos_o;
  logic          gp1_en_o;
  logic [RW-1:0] round_o;
  logic          end_flag_o;
  logic [0:0]    dbg_state_o;

  int n_checks;
  int n_pass;
  logic [BW-1:0] exp_q[$];

  memshare_sched_ctrl #(
    .SHARED_BANK_NUM (N),
    .SHARE_PORT_NUM  (2),
    .ROUND_WIDTH     (RW)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_ready_o     (rqst_ready_o),
    .share_rqstFlag_i (share_rqstFlag_i),
    .grant_valid_o    (grant_valid_o),
    .grant_ready_i    (grant_ready_i),
    .grant_o          (grant_o),
    .invalid_pos_o    (invalid_pos_o),
    .gp1_en_o         (gp1_en_o),
    .round_o          (round_o),
    .end_flag_o       (end_flag_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock generation
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Compare one scalar output
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Queue the expected beat, then compare the head against the outputs
  task automatic chk_beat(input string tag, input logic v, input logic [N-1:0] g,
                          input logic [N-1:0] inv, input logic gp1,
                          input logic [RW-1:0] rnd, input logic e);
    logic [BW-1:0] obs;
    logic [BW-1:0] exp;
    exp_q.push_back({v, g, inv, gp1, rnd, e});
    exp = exp_q.pop_front();
    obs = {grant_valid_o, grant_o, invalid_pos_o, gp1_en_o, round_o, end_flag_o};
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed v/g/inv/gp1/rnd/end=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    rst              = 1'b1;
    rqst_valid_i     = 1'b0;
    grant_ready_i    = 1'b0;
    share_rqstFlag_i = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk_beat("reset_outputs", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);
    chk_bit("reset_rqst_ready", rqst_ready_o, 1'b1);

    // All-zero snapshot: one beat, grant 0, gp1 and end set
    share_rqstFlag_i = 5'b00000;
    rqst_valid_i     = 1'b1;
    grant_ready_i    = 1'b1;
    #1 chk_bit("zero_ready_before", rqst_ready_o, 1'b1);
    step();
    chk_beat("zero_beat", 1'b1, 5'b00000, 5'b00000, 1'b1, 2'd0, 1'b1);
    rqst_valid_i = 1'b0;
    #1 chk_bit("zero_ready_during", rqst_ready_o, 1'b1);
    step();
    chk_beat("zero_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    // Two flags fit one round
    share_rqstFlag_i = 5'b10100;
    rqst_valid_i     = 1'b1;
    step();
    chk_beat("f10100_beat", 1'b1, 5'b10100, 5'b00000, 1'b1, 2'd0, 1'b1);
    rqst_valid_i = 1'b0;
    step();
    chk_beat("f10100_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    // All five flags take three rounds
    share_rqstFlag_i = 5'b11111;
    rqst_valid_i     = 1'b1;
    step();
    chk_beat("f11111_r0", 1'b1, 5'b00011, 5'b11100, 1'b1, 2'd0, 1'b0);
    rqst_valid_i = 1'b0;
    #1 chk_bit("f11111_r0_ready", rqst_ready_o, 1'b0);
    step();
    chk_beat("f11111_r1", 1'b1, 5'b01100, 5'b10000, 1'b0, 2'd1, 1'b0);
    chk_bit("f11111_r1_ready", rqst_ready_o, 1'b0);
    step();
    chk_beat("f11111_r2", 1'b1, 5'b10000, 5'b00000, 1'b0, 2'd2, 1'b1);
    chk_bit("f11111_r2_ready", rqst_ready_o, 1'b1);
    step();
    chk_beat("f11111_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    // Backpressure on round 0; flag changes during SERVE are ignored
    share_rqstFlag_i = 5'b00111;
    rqst_valid_i     = 1'b1;
    grant_ready_i    = 1'b0;
    step();
    chk_beat("f00111_r0", 1'b1, 5'b00011, 5'b00100, 1'b1, 2'd0, 1'b0);
    rqst_valid_i     = 1'b0;
    share_rqstFlag_i = 5'b11111;
    step();
    chk_beat("f00111_hold1", 1'b1, 5'b00011, 5'b00100, 1'b1, 2'd0, 1'b0);
    step();
    chk_beat("f00111_hold2", 1'b1, 5'b00011, 5'b00100, 1'b1, 2'd0, 1'b0);
    grant_ready_i = 1'b1;
    step();
    chk_beat("f00111_r1", 1'b1, 5'b00100, 5'b00000, 1'b0, 2'd1, 1'b1);
    step();
    chk_beat("f00111_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    // Reset in the middle of a three-round snapshot
    share_rqstFlag_i = 5'b11111;
    rqst_valid_i     = 1'b1;
    step();
    rqst_valid_i = 1'b0;
    step();
    chk_beat("rst_pre_r1", 1'b1, 5'b01100, 5'b10000, 1'b0, 2'd1, 1'b0);
    rst = 1'b1;
    #1 chk_beat("rst_async_clear", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);
    step();
    rst = 1'b0;
    #1 chk_beat("rst_released", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);
    chk_bit("rst_released_ready", rqst_ready_o, 1'b1);
    share_rqstFlag_i = 5'b01000;
    rqst_valid_i     = 1'b1;
    step();
    chk_beat("post_rst_beat", 1'b1, 5'b01000, 5'b00000, 1'b1, 2'd0, 1'b1);
    rqst_valid_i = 1'b0;
    step();
    chk_beat("post_rst_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    // Back-to-back single-round snapshots with no idle cycle
    share_rqstFlag_i = 5'b00001;
    rqst_valid_i     = 1'b1;
    step();
    chk_beat("b2b_first", 1'b1, 5'b00001, 5'b00000, 1'b1, 2'd0, 1'b1);
    share_rqstFlag_i = 5'b00010;
    #1 chk_bit("b2b_ready", rqst_ready_o, 1'b1);
    step();
    chk_beat("b2b_second", 1'b1, 5'b00010, 5'b00000, 1'b1, 2'd0, 1'b1);
    rqst_valid_i = 1'b0;
    step();
    chk_beat("b2b_drained", 1'b0, 5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memshare_sched_ctrl.md
# memshare_sched_ctrl

Central memory-share scheduler for subgroup 2, the partially-parallelised column banks. It takes one snapshot of per-requestor shared-access flags, produced by the access request generator, and serialises the flagged requestors onto SHARE_PORT_NUM physical shared banks over as few rounds as possible. For each round it emits a grant mask, a deferred-position mask (for L1PA shift/invalid generation) and an end flag. Non-shared (GP1) requestors are released in round 0 only.

## Interface
Parameters:
- SHARED_BANK_NUM, 5, number of requestors in the share group (GP1+GP2).
- SHARE_PORT_NUM, 2, physical shared banks in GP2; the maximum number of grants per round.
- ROUND_WIDTH, 2, round counter width; must hold ceil(SHARED_BANK_NUM/SHARE_PORT_NUM)-1.

Ports:
- sys_clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, reset. One clock; reset is asynchronous and active-high.
- rqst_valid_i, input, 1, a request snapshot is present.
- rqst_ready_o, input-side handshake output, 1, scheduler can accept a snapshot.
- share_rqstFlag_i, input, SHARED_BANK_NUM, '1' means requestor i needs a GP2 bank.
- grant_valid_o, output, 1, one round beat is valid.
- grant_ready_i, input, 1, downstream consumes the beat.
- grant_o, output, SHARED_BANK_NUM, GP2 requestors served this round.
- invalid_pos_o, output, SHARED_BANK_NUM, flagged requestors deferred past this round.
- gp1_en_o, output, 1, GP1 requestors are served in this beat (round 0 only).
- round_o, output, ROUND_WIDTH, round index of the beat.
- end_flag_o, output, 1, last round of the snapshot.

## Operation
- States are IDLE and SERVE. Internal pending mask is SHARED_BANK_NUM bits.
- pick(m) returns the lowest-index SHARE_PORT_NUM set bits of m, or all set bits if fewer.
- beat_free = !grant_valid_o || grant_ready_i.
- rqst_ready_o = (state==IDLE) && beat_free. It is combinational.
- Accept (rqst_valid_i && rqst_ready_o), registering:
  - grant_o <= pick(flags)
  - pending <= flags & ~pick(flags)
  - invalid_pos_o <= flags & ~pick(flags)
  - gp1_en_o <= 1, round_o <= 0, grant_valid_o <= 1
  - end_flag_o <= (remaining==0)
  - state <= SERVE if remaining != 0, else IDLE
- All-zero flags give one beat: grant 0, gp1_en 1, end 1.
- SERVE, on grant_ready_i, registering:
  - grant_o <= pick(pending)
  - pending <= pending & ~pick(pending)
  - invalid_pos_o <= the new pending value
  - gp1_en_o <= 0, round_o <= round_o+1
  - end_flag_o <= (new pending==0); if so, state <= IDLE
- SERVE without grant_ready_i holds all registers and outputs.
- IDLE with grant_ready_i and no accept drops grant_valid_o to 0. grant_o, invalid_pos_o, round_o and end_flag_o clear to 0 with it.
- A snapshot needs max(1, ceil(popcount/SHARE_PORT_NUM)) beats. round_o never wraps within a snapshot.
- Snapshot inputs are sampled only on accept; changes to them during SERVE are ignored.

## Timing
- Reset values: state IDLE, pending 0, grant_valid_o 0, grant_o 0, invalid_pos_o 0, gp1_en_o 0, round_o 0, end_flag_o 0. rqst_ready_o reads 1 after reset.
- Latency: first beat is valid in the cycle after the accept edge.
- Throughput:
  - Single-round snapshots with grant_ready_i held high: one snapshot per cycle, back-to-back.
  - Multi-round snapshots: the next accept occurs on the same edge that the end beat is consumed.
- Beats are consumed only when grant_valid_o && grant_ready_i. Outputs must stay stable while grant_valid_o && !grant_ready_i.
- rst asserted mid-SERVE drops the snapshot immediately: outputs go to reset values asynchronously. No partial beat follows deassertion.

## Structure
- Shared package memshare_pkg holds:
  - the state encoding (IDLE, SERVE)
  - the default SHARE_PORT_NUM
  - a function for the round count, ceil(N/P)
- Sub-module lowest_k_select: a combinational picker with parameters N and K, input mask, output the lowest K set bits. It is instantiated once and muxed between share_rqstFlag_i (IDLE) and pending (SERVE).

## Test plan
All scenarios use SHARED_BANK_NUM=5 and SHARE_PORT_NUM=2.
- Flags 00000, grant_ready_i=1: one beat with grant 00000, invalid 00000, gp1_en 1, round 0, end 1. rqst_ready_o stays 1.
- Flags 10100: one beat with grant 10100, invalid 00000, end 1.
- Flags 11111, grant_ready_i=1: three beats.
  - Round 0: grant 00011, invalid 11100, gp1_en 1.
  - Round 1: grant 01100, invalid 10000, gp1_en 0.
  - Round 2: grant 10000, invalid 00000, end 1.
  - rqst_ready_o is 0 during rounds 0-1.
- Flags 00111 with grant_ready_i low for 2 cycles on round 0: grant 00011 and invalid 00100 are held unchanged. Round 1 then gives grant 00100, end 1.
- rst pulsed during round 1 of flags 11111: all outputs 0 immediately. The next accept of 01000 yields a single beat with grant 01000, end 1.
- rqst_valid_i held with snapshots 00001 then 00010 and grant_ready_i=1: two consecutive beats, both with end 1 and round 0, and no idle cycle between them.
